// File: rtl/apb_pkg.sv
// Shared types for the APB master: FSM states, response status codes and
// the slave-select width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STS_OK      = 2'b00,
        STS_SLVERR  = 2'b01,
        STS_TIMEOUT = 2'b10,
        STS_DECERR  = 2'b11
    } status_t;

    // At least one select bit, even for a single slave.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Command, response and APB fabric signals of the multi-slave APB master.
interface apb_master_nslv_if
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_W-1:0]         cmd_addr;
    logic                      cmd_write;
    logic [DATA_W-1:0]         cmd_wdata;
    logic [DATA_W/8-1:0]       cmd_strb;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;
    status_t                   rsp_status;

    logic [ADDR_W-1:0]         apb_addr;
    logic                      apb_write;
    logic [NUM_SLV-1:0]        apb_selx;
    logic                      apb_en;
    logic [DATA_W-1:0]         apb_wdata;
    logic [DATA_W/8-1:0]       apb_strb;
    logic [NUM_SLV*DATA_W-1:0] apb_rdata;
    logic [NUM_SLV-1:0]        apb_ready;
    logic [NUM_SLV-1:0]        apb_slverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, rsp_ready,
               apb_rdata, apb_ready, apb_slverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
               apb_addr, apb_write, apb_selx, apb_en, apb_wdata, apb_strb
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, rsp_ready,
               apb_rdata, apb_ready, apb_slverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
               apb_addr, apb_write, apb_selx, apb_en, apb_wdata, apb_strb
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-cycle counter; expired flags the TIMEOUT-th enabled cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
            localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    r_cnt <= '0;
                end else if (enable && (r_cnt != LIMIT)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // r_cnt holds the cycles already spent, so this cycle is the last one.
            assign expired = enable && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master_nslv.sv
// APB4 master bridging a valid/ready command port onto NUM_SLV decoded slaves,
// with slave-error capture, decode errors and an ACCESS-phase timeout.
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 20
) (
    input logic               apb_clk,
    input logic               apb_reset_n,
    apb_master_nslv_if.master bus
);

    localparam int SEL_W  = sel_w(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    status_t             r_status;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [NUM_SLV-1:0]  r_selx;
    logic                r_en;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;

    logic [SEL_W-1:0]    w_idx;
    logic                w_decerr;
    logic [NUM_SLV-1:0]  w_onehot;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_ready;
    logic                w_slverr;
    logic                w_expired;

    assign w_idx    = bus.cmd_addr[ADDR_W-1 -: SEL_W];
    assign w_decerr = (int'(w_idx) >= NUM_SLV);
    assign w_onehot = NUM_SLV'(1) << w_idx;

    // The registered one-hot select doubles as the response mux control.
    always_comb begin
        w_rdata  = '0;
        w_ready  = 1'b0;
        w_slverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_selx[i]) begin
                w_rdata  = w_rdata | bus.apb_rdata[i*DATA_W +: DATA_W];
                w_ready  = w_ready | bus.apb_ready[i];
                w_slverr = w_slverr | bus.apb_slverr[i];
            end
        end
    end

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (apb_clk),
        .rst_n   (apb_reset_n),
        .clear   (r_state != ST_ACCESS),
        .enable  (r_state == ST_ACCESS),
        .expired (w_expired)
    );

    always_ff @(posedge apb_clk) begin
        if (!apb_reset_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_status    <= STS_OK;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_selx      <= '0;
            r_en        <= 1'b0;
            r_wdata     <= '0;
            r_strb      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= bus.cmd_addr;
                        r_write     <= bus.cmd_write;
                        r_wdata     <= bus.cmd_write ? bus.cmd_wdata : '0;
                        r_strb      <= bus.cmd_write ? bus.cmd_strb  : '0;
                        if (w_decerr) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_status    <= STS_DECERR;
                        end else begin
                            r_state <= ST_SETUP;
                            r_selx  <= w_onehot;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_en    <= 1'b1;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so it wins on the final timed cycle.
                    if (w_ready) begin
                        r_state     <= ST_RESP;
                        r_selx      <= '0;
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_status    <= w_slverr ? STS_SLVERR : STS_OK;
                        r_rsp_rdata <= (!r_write && !w_slverr) ? w_rdata : '0;
                    end else if (w_expired) begin
                        r_state     <= ST_RESP;
                        r_selx      <= '0;
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_status    <= STS_TIMEOUT;
                        r_rsp_rdata <= '0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_status = r_status;
    assign bus.apb_addr   = r_addr;
    assign bus.apb_write  = r_write;
    assign bus.apb_selx   = r_selx;
    assign bus.apb_en     = r_en;
    assign bus.apb_wdata  = r_wdata;
    assign bus.apb_strb   = r_strb;

endmodule
